sega_joy_scan: RTL and testbench

SEGA_JOY_SCAN -- requirements
Module: sega_joy_scan

---
 rtl/joy_pkg.sv | 49 ++++
 rtl/sega_port_decode.sv | 71 +++++++
 rtl/sega_joy_scan.sv | 102 ++++++++++
 tb/tb_sega_joy_scan.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_pkg.sv
// Shared definitions for the Sega DB9 pad scanner: frame phases, pad types,
// and the bit positions used in the decoded button word and raw pin group.
package joy_pkg;

  typedef enum logic [3:0] {
    PH0  = 4'd0,
    PH1  = 4'd1,
    PH2  = 4'd2,
    PH3  = 4'd3,
    PH4  = 4'd4,
    PH5  = 4'd5,
    PH6  = 4'd6,
    PH7  = 4'd7,
    IDLE = 4'd8
  } phase_e;

  localparam logic [1:0] TYPE_ATARI = 2'd0;
  localparam logic [1:0] TYPE_MD3   = 2'd1;
  localparam logic [1:0] TYPE_MD6   = 2'd2;

  // Decoded button word, active high: {Mode,X,Y,Z,Start,A,C,B,R,L,D,U}
  localparam int BIT_U     = 0;
  localparam int BIT_D     = 1;
  localparam int BIT_L     = 2;
  localparam int BIT_R     = 3;
  localparam int BIT_B     = 4;
  localparam int BIT_C     = 5;
  localparam int BIT_A     = 6;
  localparam int BIT_START = 7;
  localparam int BIT_Z     = 8;
  localparam int BIT_Y     = 9;
  localparam int BIT_X     = 10;
  localparam int BIT_MODE  = 11;

  // Raw pin group per port, active low: {p9,p6,right,left,down,up}
  localparam int PIN_UP    = 0;
  localparam int PIN_DOWN  = 1;
  localparam int PIN_LEFT  = 2;
  localparam int PIN_RIGHT = 3;
  localparam int PIN_P6    = 4;
  localparam int PIN_P9    = 5;

  function automatic logic [1:0] pad_type(input logic md, input logic six);
    if (six)     return TYPE_MD6;
    else if (md) return TYPE_MD3;
    else         return TYPE_ATARI;
  endfunction

endpackage

// File: rtl/sega_port_decode.sv
// Per-port shadow decoder: samples one DB9 port at the end of selected phases
// and builds the button word plus the MD/6-button detection flags.
module sega_port_decode
  import joy_pkg::*;
(
  input  logic        clk_i,
  input  logic        res_n_i,
  input  phase_e      phase_i,
  input  logic        sample_i,
  input  logic [5:0]  pins_i,
  output logic [11:0] btn_o,
  output logic [1:0]  type_o
);

  logic [11:0] btn_q;
  logic        md_q;
  logic        six_q;
  logic [5:0]  act;

  assign act = ~pins_i;

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      btn_q <= '0;
      md_q  <= 1'b0;
      six_q <= 1'b0;
    end else if (sample_i) begin
      case (phase_i)
        PH0: begin
          btn_q[BIT_U] <= act[PIN_UP];
          btn_q[BIT_D] <= act[PIN_DOWN];
          btn_q[BIT_L] <= act[PIN_LEFT];
          btn_q[BIT_R] <= act[PIN_RIGHT];
          btn_q[BIT_B] <= act[PIN_P6];
          btn_q[BIT_C] <= act[PIN_P9];
        end
        PH1: begin
          // An MD pad grounds left and right while select is low
          if (!pins_i[PIN_LEFT] && !pins_i[PIN_RIGHT]) begin
            md_q             <= 1'b1;
            btn_q[BIT_A]     <= act[PIN_P6];
            btn_q[BIT_START] <= act[PIN_P9];
          end else begin
            md_q             <= 1'b0;
            btn_q[BIT_A]     <= 1'b0;
            btn_q[BIT_START] <= 1'b0;
          end
        end
        PH5: six_q <= md_q && (pins_i[3:0] == 4'b0000);
        PH6: begin
          if (six_q) begin
            btn_q[BIT_Z]    <= act[PIN_UP];
            btn_q[BIT_Y]    <= act[PIN_DOWN];
            btn_q[BIT_X]    <= act[PIN_LEFT];
            btn_q[BIT_MODE] <= act[PIN_RIGHT];
          end else begin
            btn_q[BIT_Z]    <= 1'b0;
            btn_q[BIT_Y]    <= 1'b0;
            btn_q[BIT_X]    <= 1'b0;
            btn_q[BIT_MODE] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign btn_o  = btn_q;
  assign type_o = pad_type(md_q, six_q);

endmodule

// File: rtl/sega_joy_scan.sv
// Sega DB9 pad scanner: drives the shared select line through an 8-phase
// frame plus idle gap, and commits every port's decoded state at idle entry.
module sega_joy_scan
  import joy_pkg::*;
#(
  parameter int NUM_PORTS    = 2,
  parameter int PHASE_CYCLES = 500,
  parameter int IDLE_PHASES  = 200
) (
  input  logic                    clk_i,
  input  logic                    res_n_i,
  input  logic [NUM_PORTS*6-1:0]  joy_i,
  output logic                    p7_o,
  output logic [NUM_PORTS*12-1:0] joy_o,
  output logic [NUM_PORTS*2-1:0]  type_o,
  output logic                    valid_o,
  output phase_e                  dbg_state_o
);

  localparam int CW = $clog2(PHASE_CYCLES);
  localparam int IW = (IDLE_PHASES > 1) ? $clog2(IDLE_PHASES) : 1;

  logic [CW-1:0] cnt_q;
  logic [IW-1:0] idle_q;
  phase_e        state_q;
  phase_e        state_d;
  logic          phase_end;
  logic          idle_last;
  logic          commit;

  logic [NUM_PORTS*12-1:0] shadow_btn;
  logic [NUM_PORTS*2-1:0]  shadow_type;

  assign phase_end = (cnt_q == CW'(PHASE_CYCLES - 1));
  assign idle_last = (idle_q == IW'(IDLE_PHASES - 1));

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)       cnt_q <= '0;
    else if (phase_end) cnt_q <= '0;
    else                cnt_q <= cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i)                          idle_q <= '0;
    else if (state_q == IDLE && phase_end) idle_q <= idle_last ? '0 : idle_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) state_q <= PH0;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    p7_o    = 1'b1;
    commit  = 1'b0;
    if (phase_end) begin
      if (state_q == IDLE) begin
        if (idle_last) state_d = PH0;
      end else if (state_q == PH7) begin
        state_d = IDLE;
        commit  = 1'b1;
      end else begin
        state_d = phase_e'(state_q + 4'd1);
      end
    end
    // Select is low on the odd phases only
    case (state_q)
      PH1, PH3, PH5, PH7: p7_o = 1'b0;
      default:            p7_o = 1'b1;
    endcase
  end

  assign dbg_state_o = state_q;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    sega_port_decode u_dec (
      .clk_i    (clk_i),
      .res_n_i  (res_n_i),
      .phase_i  (state_q),
      .sample_i (phase_end),
      .pins_i   (joy_i[p*6 +: 6]),
      .btn_o    (shadow_btn[p*12 +: 12]),
      .type_o   (shadow_type[p*2 +: 2])
    );
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      joy_o   <= '0;
      type_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= commit;
      if (commit) begin
        joy_o  <= shadow_btn;
        type_o <= shadow_type;
      end
    end
  end

endmodule

// File: tb/tb_sega_joy_scan.sv
// Bench for sega_joy_scan: behavioural Atari / MD 3-button / MD 6-button pad
// models on two ports, a table of per-frame vectors, and timing sequences.
module tb_sega_joy_scan;
  import joy_pkg::*;

  localparam int NP    = 2;
  localparam int PC    = 4;
  localparam int IP    = 150;
  localparam int FRAME = (8 + IP) * PC;

  localparam int PAD_ATARI = 0;
  localparam int PAD_MD3   = 1;
  localparam int PAD_MD6   = 2;

  // clock / reset
  logic clk = 1'b0;
  logic res_n;
  always #5 clk = ~clk;

  logic [NP*6-1:0]  joy_i;
  logic             p7;
  logic [NP*12-1:0] joy_o;
  logic [NP*2-1:0]  type_o;
  logic             valid;
  phase_e           dbg;

  sega_joy_scan #(
    .NUM_PORTS    (NP),
    .PHASE_CYCLES (PC),
    .IDLE_PHASES  (IP)
  ) dut (
    .clk_i       (clk),
    .res_n_i     (res_n),
    .joy_i       (joy_i),
    .p7_o        (p7),
    .joy_o       (joy_o),
    .type_o      (type_o),
    .valid_o     (valid),
    .dbg_state_o (dbg)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // pad models: select-edge counter restarts after a long high stretch
  int          pad_type [NP];
  logic [11:0] pad_btn  [NP];
  int          sel_idx;
  int          high_run;
  logic        p7_q;

  always @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sel_idx  <= 0;
      high_run <= 0;
      p7_q     <= 1'b1;
    end else begin
      if (p7 != p7_q)          sel_idx <= sel_idx + 1;
      else if (high_run > 2*PC) sel_idx <= 0;
      high_run <= p7 ? high_run + 1 : 0;
      p7_q     <= p7;
    end
  end

  function automatic logic [5:0] pad_pins(input int typ, input logic [11:0] b, input int idx);
    logic [5:0] hi_pins;
    logic [5:0] lo_pins;
    hi_pins = {~b[5], ~b[4], ~b[3], ~b[2], ~b[1], ~b[0]};
    lo_pins = {~b[7], ~b[6], 1'b0, 1'b0, ~b[1], ~b[0]};
    if (typ == PAD_ATARI) return hi_pins;
    if (typ == PAD_MD6 && idx == 5) return {~b[7], ~b[6], 4'b0000};
    if (typ == PAD_MD6 && idx == 6) return {~b[5], ~b[4], ~b[11], ~b[10], ~b[9], ~b[8]};
    return (idx % 2 == 0) ? hi_pins : lo_pins;
  endfunction

  always_comb begin
    joy_i = '0;
    for (int p = 0; p < NP; p++) joy_i[p*6 +: 6] = pad_pins(pad_type[p], pad_btn[p], sel_idx);
  end

  // scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string what);
    bit seen;
    seen = 0;
    for (int n = 0; n < 2*FRAME && !seen; n++) begin
      @(negedge clk);
      if (valid) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout waiting valid actual=0 required=1", what);
    end
  endtask

  task automatic wait_state(input phase_e s, input string what);
    bit seen;
    seen = 0;
    for (int n = 0; n < 2*FRAME && !seen; n++) begin
      @(negedge clk);
      if (dbg == s) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL %s timeout waiting state actual=%0d required=%0d", what, dbg, s);
    end
  endtask

  // counts negedges from now until valid is seen
  task automatic count_to_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 2*FRAME);
  endtask

  // monitors joy_o/type_o against a fixed value until the next commit
  task automatic hold_until_valid(input logic [23:0] ej, input logic [3:0] et, output int bad);
    int n;
    bad = 0;
    n   = 0;
    do begin
      @(negedge clk);
      n++;
      if (!valid && (joy_o !== ej || type_o !== et)) bad++;
    end while (!valid && n < 2*FRAME);
    if (!valid) bad++;
  endtask

  typedef struct {
    int          t0;
    logic [11:0] b0;
    int          t1;
    logic [11:0] b1;
    logic [11:0] e0;
    logic [1:0]  et0;
    logic [11:0] e1;
    logic [1:0]  et1;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    int bad;
    int t_prev;
    int toggles;
    int lows;
    logic p7_prev;

    vecs[0] = '{PAD_ATARI, 12'h011, PAD_MD3,   12'h0A0, 12'h011, 2'd0, 12'h0A0, 2'd1};
    vecs[1] = '{PAD_MD6,   12'hC00, PAD_ATARI, 12'h028, 12'hC00, 2'd2, 12'h028, 2'd0};
    vecs[2] = '{PAD_MD3,   12'hC01, PAD_MD6,   12'hFFF, 12'h001, 2'd1, 12'hFFF, 2'd2};
    vecs[3] = '{PAD_ATARI, 12'h01C, PAD_MD3,   12'h000, 12'h05C, 2'd1, 12'h000, 2'd1};
    vecs[4] = '{PAD_MD6,   12'h3FF, PAD_MD6,   12'h000, 12'h3FF, 2'd2, 12'h000, 2'd2};
    vecs[5] = '{PAD_MD3,   12'h04F, PAD_ATARI, 12'h000, 12'hF4F, 2'd2, 12'h000, 2'd0};

    for (int p = 0; p < NP; p++) begin
      pad_type[p] = PAD_ATARI;
      pad_btn[p]  = 12'h000;
    end

    // reset state
    res_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_p7", 32'(p7), 32'd1);
    check("rst_joy", 32'(joy_o), 32'd0);
    check("rst_type", 32'(type_o), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_state", 32'(dbg), 32'(PH0));
    res_n = 1'b1;
    count_to_valid(n);
    check("first_valid_latency", 32'(n), 32'(8*PC));

    // table of per-frame vectors; pads change in IDLE so the next frame is clean
    for (int v = 0; v < 6; v++) begin
      pad_type[0] = vecs[v].t0;
      pad_btn[0]  = vecs[v].b0;
      pad_type[1] = vecs[v].t1;
      pad_btn[1]  = vecs[v].b1;
      wait_valid($sformatf("vec%0d", v));
      check($sformatf("vec%0d_joy0", v), 32'(joy_o[11:0]), 32'(vecs[v].e0));
      check($sformatf("vec%0d_type0", v), 32'(type_o[1:0]), 32'(vecs[v].et0));
      check($sformatf("vec%0d_joy1", v), 32'(joy_o[23:12]), 32'(vecs[v].e1));
      check($sformatf("vec%0d_type1", v), 32'(type_o[3:2]), 32'(vecs[v].et1));
    end

    // 6-button pad swapped for a 3-button pad
    pad_type[0] = PAD_MD6;
    pad_btn[0]  = 12'hC00;
    pad_type[1] = PAD_ATARI;
    pad_btn[1]  = 12'h000;
    wait_valid("swap_pre");
    check("swap_pre_joy0", 32'(joy_o[11:0]), 32'h0C00);
    check("swap_pre_type0", 32'(type_o[1:0]), 32'd2);
    pad_type[0] = PAD_MD3;
    hold_until_valid({12'h000, 12'hC00}, {2'd0, 2'd2}, bad);
    check("swap_hold_stable", 32'(bad), 32'd0);
    check("swap_post_joy0", 32'(joy_o[11:0]), 32'h0000);
    check("swap_post_type0", 32'(type_o[1:0]), 32'd1);

    // button pressed after the PH0 sample is not seen until the frame after
    pad_type[1] = PAD_MD3;
    wait_valid("mid_pre");
    check("mid_pre_joy1", 32'(joy_o[23:12]), 32'h0000);
    wait_state(PH1, "mid_ph1");
    pad_btn[1] = 12'h010;
    hold_until_valid(24'h000000, {2'd1, 2'd1}, bad);
    check("mid_hold_stable", 32'(bad), 32'd0);
    check("mid_commit_joy1", 32'(joy_o[23:12]), 32'h0000);
    wait_valid("mid_next");
    check("mid_next_joy1", 32'(joy_o[23:12]), 32'h0010);

    // reset pulse in PH5 aborts the frame
    wait_state(PH5, "rst5_ph5");
    res_n = 1'b0;
    #1;
    check("rst5_joy", 32'(joy_o), 32'd0);
    check("rst5_type", 32'(type_o), 32'd0);
    check("rst5_p7", 32'(p7), 32'd1);
    check("rst5_valid", 32'(valid), 32'd0);
    repeat (2) @(negedge clk);
    check("rst5_valid_held", 32'(valid), 32'd0);
    check("rst5_state", 32'(dbg), 32'(PH0));
    res_n = 1'b1;
    count_to_valid(n);
    check("rst5_latency", 32'(n), 32'(8*PC));
    check("rst5_after_joy1", 32'(joy_o[23:12]), 32'h0010);
    check("rst5_after_type1", 32'(type_o[3:2]), 32'd1);

    // free run: frame period, select toggles and low time per frame
    for (int f = 0; f < 3; f++) begin
      t_prev  = cyc;
      toggles = 0;
      lows    = 0;
      p7_prev = p7;
      n       = 0;
      do begin
        @(negedge clk);
        n++;
        if (p7 != p7_prev) toggles++;
        if (!p7) lows++;
        p7_prev = p7;
      end while (!valid && n < 2*FRAME);
      check($sformatf("run%0d_period", f), 32'(cyc - t_prev), 32'(FRAME));
      check($sformatf("run%0d_toggles", f), 32'(toggles), 32'd8);
      check($sformatf("run%0d_low_cycles", f), 32'(lows), 32'(4*PC));
    end
    @(negedge clk);
    check("valid_one_cycle", 32'(valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
